// File: rtl/fifo_flags.sv
// fifo_flags: parametrised synchronous FIFO with programmable almost-full /
// almost-empty flags, occupancy level, optional first-word-fall-through read,
// synchronous flush and sticky overflow/underflow error flags.
//
// Ports
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   flush               synchronous clear of contents (errors and r_data kept)
//   clr_err             synchronous clear of overflow/underflow
//   wr_en, w_data       write request and data
//   rd_en               read / pop request
//   r_data, r_valid     read data and its qualifier
//   empty, full         level == 0 / level == FIFO_DEPTH
//   almost_empty        level <= AE_THRESH
//   almost_full         level >= AF_THRESH
//   level               current occupancy
//   overflow, underflow sticky error flags
module fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 4,
  parameter int FWFT       = 0
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            flush,
  input  logic                            clr_err,
  input  logic                            wr_en,
  input  logic [DATA_WIDTH-1:0]           w_data,
  input  logic                            rd_en,
  output logic [DATA_WIDTH-1:0]           r_data,
  output logic                            r_valid,
  output logic                            empty,
  output logic                            full,
  output logic                            almost_empty,
  output logic                            almost_full,
  output logic [$clog2(FIFO_DEPTH):0]     level,
  output logic                            overflow,
  output logic                            underflow
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = ADDR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] AF_LVL    = LVL_W'(AF_THRESH);
  localparam logic [LVL_W-1:0] AE_LVL    = LVL_W'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]     w_ptr;
  logic [ADDR_W-1:0]     r_ptr;
  logic [LVL_W-1:0]      level_q;
  logic                  ovf_q;
  logic                  unf_q;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  ovf_set;
  logic                  unf_set;

  // Flags come straight from the registered level.
  assign level        = level_q;
  assign empty        = (level_q == '0);
  assign full         = (level_q == DEPTH_LVL);
  assign almost_empty = (level_q <= AE_LVL);
  assign almost_full  = (level_q >= AF_LVL);
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // A flush cycle swallows both requests, so neither is accepted nor flagged.
  // When full, an accepted read frees the slot the write needs.
  assign rd_acc  = !flush && rd_en && !empty;
  assign wr_acc  = !flush && wr_en && (!full || rd_acc);
  assign ovf_set = !flush && wr_en && !wr_acc;
  assign unf_set = !flush && rd_en && !rd_acc;

  // Storage: no reset on the array, contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[w_ptr] <= w_data;
  end

  // Pointers, level and sticky errors.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_ptr   <= '0;
      r_ptr   <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (flush) begin
      w_ptr   <= '0;
      r_ptr   <= '0;
      level_q <= '0;
    end else begin
      if (wr_acc) w_ptr <= w_ptr + ADDR_W'(1);
      if (rd_acc) r_ptr <= r_ptr + ADDR_W'(1);
      if (wr_acc && !rd_acc)      level_q <= level_q + LVL_W'(1);
      else if (rd_acc && !wr_acc) level_q <= level_q - LVL_W'(1);
      // Setting an error wins over clearing it in the same cycle.
      if (ovf_set)      ovf_q <= 1'b1;
      else if (clr_err) ovf_q <= 1'b0;
      if (unf_set)      unf_q <= 1'b1;
      else if (clr_err) unf_q <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented combinationally; a pop just advances r_ptr.
      assign r_data  = empty ? '0 : mem[r_ptr];
      assign r_valid = !empty;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] r_data_p1;
      logic                  vld_p1;

      // Stage p1: popped word registered one cycle after the accepted read.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_data_p1 <= '0;
          vld_p1    <= 1'b0;
        end else begin
          if (rd_acc) r_data_p1 <= mem[r_ptr];
          vld_p1 <= rd_acc;
        end
      end

      assign r_data  = r_data_p1;
      assign r_valid = vld_p1;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_flags.sv
// Testbench for fifo_flags: a registered-read instance driven against a
// reference queue model with a scoreboard of expected read words, plus a small
// first-word-fall-through instance exercised directly.
module tb_fifo_flags;

  logic       clk;
  logic       reset_n;
  logic       flush, clr_err, wr_en, rd_en;
  logic [7:0] w_data;
  logic [7:0] r_data;
  logic       r_valid, empty, full, almost_empty, almost_full, overflow, underflow;
  logic [4:0] level;

  logic       f_wr_en, f_rd_en;
  logic [7:0] f_w_data;
  logic [7:0] f_r_data;
  logic       f_r_valid, f_empty, f_full, f_ae, f_af, f_ovf, f_unf;
  logic [4:0] f_level;

  fifo_flags #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .AF_THRESH(12), .AE_THRESH(4), .FWFT(0)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .clr_err(clr_err),
    .wr_en(wr_en), .w_data(w_data), .rd_en(rd_en),
    .r_data(r_data), .r_valid(r_valid), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .level(level),
    .overflow(overflow), .underflow(underflow)
  );

  fifo_flags #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .AF_THRESH(12), .AE_THRESH(4), .FWFT(1)) dut_fwft (
    .clk(clk), .reset_n(reset_n), .flush(1'b0), .clr_err(1'b0),
    .wr_en(f_wr_en), .w_data(f_w_data), .rd_en(f_rd_en),
    .r_data(f_r_data), .r_valid(f_r_valid), .empty(f_empty), .full(f_full),
    .almost_empty(f_ae), .almost_full(f_af), .level(f_level),
    .overflow(f_ovf), .underflow(f_unf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model state.
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  logic       m_ovf, m_unf, m_rv;
  logic [7:0] m_rdata;

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_rv = 1'b0; m_rdata = 8'h00;
  endtask

  task automatic drive(input logic w, input logic r, input logic [7:0] d,
                       input logic f = 1'b0, input logic c = 1'b0);
    wr_en = w; rd_en = r; w_data = d; flush = f; clr_err = c;
  endtask

  // Advance one clock: update the model from the driven inputs, then check
  // every output of the registered-read instance just after the edge.
  task automatic step();
    logic racc, wacc, oset, uset;
    racc = 1'b0; wacc = 1'b0; oset = 1'b0; uset = 1'b0;
    if (flush) begin
      mq.delete();
    end else begin
      racc = rd_en && (mq.size() != 0);
      wacc = wr_en && ((mq.size() != 16) || racc);
      oset = wr_en && !wacc;
      uset = rd_en && !racc;
      if (racc) begin
        m_rdata = mq.pop_front();
        exp_q.push_back(m_rdata);
      end
      if (wacc) mq.push_back(w_data);
      m_ovf = oset | (m_ovf & ~clr_err);
      m_unf = uset | (m_unf & ~clr_err);
    end
    m_rv = racc;
    @(posedge clk); #1;
    chk("level",        32'(level),        32'(mq.size()));
    chk("empty",        32'(empty),        32'(mq.size() == 0));
    chk("full",         32'(full),         32'(mq.size() == 16));
    chk("almost_empty", 32'(almost_empty), 32'(mq.size() <= 4));
    chk("almost_full",  32'(almost_full),  32'(mq.size() >= 12));
    chk("overflow",     32'(overflow),     32'(m_ovf));
    chk("underflow",    32'(underflow),    32'(m_unf));
    chk("r_valid",      32'(r_valid),      32'(m_rv));
    if (r_valid) begin
      if (exp_q.size() == 0) chk("sb_unexpected_word", 32'(1), 32'(0));
      else chk("r_data", 32'(r_data), 32'(exp_q.pop_front()));
    end else begin
      chk("r_data_hold", 32'(r_data), 32'(m_rdata));
    end
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    f_wr_en = 1'b0; f_rd_en = 1'b0; f_w_data = 8'h00;
    model_reset();
    #2;
    chk("rst_level", 32'(level), 32'(0));
    chk("rst_empty", 32'(empty), 32'(1));
    chk("rst_ae",    32'(almost_empty), 32'(1));
    chk("rst_rvalid", 32'(r_valid), 32'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Reset while holding 5 words and a non-zero r_data.
    for (int i = 0; i < 6; i++) begin drive(1'b1, 1'b0, 8'h30 + 8'(i)); step(); end
    drive(1'b0, 1'b1, 8'h00); step();
    drive(1'b0, 1'b0, 8'h00); step();
    chk("pre_rst_level", 32'(level), 32'(5));
    #3 reset_n = 1'b0;
    #1;
    chk("arst_level", 32'(level), 32'(0));
    chk("arst_empty", 32'(empty), 32'(1));
    chk("arst_rdata", 32'(r_data), 32'(0));
    chk("arst_rvalid", 32'(r_valid), 32'(0));
    chk("arst_af", 32'(almost_full), 32'(0));
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Fill 0x00..0x0F, then one write too many.
    for (int i = 0; i < 17; i++) begin drive(1'b1, 1'b0, 8'(i)); step(); end
    drive(1'b0, 1'b0, 8'h00); step();
    for (int i = 0; i < 16; i++) begin drive(1'b0, 1'b1, 8'h00); step(); end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1); step();
    step();

    // Refill, then simultaneous read/write while full.
    for (int i = 0; i < 16; i++) begin drive(1'b1, 1'b0, 8'(i)); step(); end
    drive(1'b1, 1'b1, 8'hAA); step();
    chk("full_rw_level", 32'(level), 32'(16));
    for (int i = 0; i < 16; i++) begin drive(1'b0, 1'b1, 8'h00); step(); end
    drive(1'b0, 1'b0, 8'h00); step();

    // Read while empty, error set beats clear in the same cycle, then clear.
    drive(1'b0, 1'b1, 8'h00); step();
    drive(1'b0, 1'b1, 8'h00, 1'b0, 1'b1); step();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1); step();
    drive(1'b0, 1'b0, 8'h00); step();

    // Flush at level 7 with a write pending.
    for (int i = 0; i < 7; i++) begin drive(1'b1, 1'b0, 8'h50 + 8'(i)); step(); end
    drive(1'b1, 1'b1, 8'h77, 1'b1); step();
    chk("flush_level", 32'(level), 32'(0));

    // 40 write/read pairs, crossing the pointer wrap several times.
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 1'b0, 8'h80 + 8'(i)); step();
      chk("pair_lvl_le1", 32'(level <= 1), 32'(1));
      drive(1'b0, 1'b1, 8'h00); step();
    end
    drive(1'b0, 1'b0, 8'h00); step();
    chk("sb_drained", 32'(exp_q.size()), 32'(0));

    // First-word-fall-through instance.
    chk("fwft_empty0",  32'(f_empty),   32'(1));
    chk("fwft_rvalid0", 32'(f_r_valid), 32'(0));
    chk("fwft_rdata0",  32'(f_r_data),  32'(0));
    f_wr_en = 1'b1; f_w_data = 8'hA5;
    @(posedge clk); #1;
    f_wr_en = 1'b0;
    chk("fwft_rdata",  32'(f_r_data),  32'(8'hA5));
    chk("fwft_rvalid", 32'(f_r_valid), 32'(1));
    chk("fwft_level",  32'(f_level),   32'(1));
    f_rd_en = 1'b1;
    @(posedge clk); #1;
    f_rd_en = 1'b0;
    chk("fwft_empty1",  32'(f_empty),   32'(1));
    chk("fwft_rvalid1", 32'(f_r_valid), 32'(0));
    chk("fwft_rdata1",  32'(f_r_data),  32'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
